stack_cmd_sequencer: RTL and testbench
======================================

Name: stack_cmd_sequencer

Overview:
- Front-end for the 8-stack unit.
- Accepts tagged stack commands from the TTA move/execute stage through a valid/ready request port and buffers them in a small FIFO.
- Issues each command to the stack unit with the timing that unit requires, then captures pop/index-read data and overflow/underflow status.
- Returns one tagged response per command through a valid/ready response port, and keeps sticky per-stack error flags.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the opaque request tag echoed in the response.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  FIFO not full.
- req_op_i  in  2  0=PUSH, 1=POP, 2=IDX_RD, 3=IDX_WR.
- req_stack_i  in  3  stack select.
- req_offset_i  in  6  index offset; 0 = top of stack.
- req_data_i  in  32  push/index-write data.
- req_tag_i  in  TAG_W  request tag.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response accepted.
- resp_data_o  out  32  pop/index-read data; 0 for PUSH/IDX_WR.
- resp_op_o  out  2  echoed op.
- resp_tag_o  out  TAG_W  echoed tag.
- resp_err_o  out  1  overflow or underflow reported for this command.
- stk_select_o  out  3  to stack unit.
- stk_push_o  out  1  to stack unit.
- stk_pop_o  out  1  to stack unit.
- stk_index_read_o  out  1  to stack unit.
- stk_index_write_o  out  1  to stack unit.
- stk_offset_o  out  6  to stack unit.
- stk_data_o  out  32  to stack unit.
- stk_data_i  in  32  stack unit data output.
- stk_ready_i  in  1  stack unit ready.
- stk_overflow_i  in  1  stack unit overflow pulse.
- stk_underflow_i  in  1  stack unit underflow pulse.
- ovf_sticky_o  out  8  per-stack sticky overflow.
- unf_sticky_o  out  8  per-stack sticky underflow.
- sticky_clear_i  in  1  clear both sticky vectors.
- busy_o  out  1  FIFO non-empty or FSM not idle.

Behaviour:
- Reset (rst_ni low, async): FIFO emptied, FSM to S_IDLE, all outputs 0 except req_ready_o=1.
  - Reset mid-command abandons the command with no response.
  - Resetting the stack unit is the top level's job.
- FIFO:
  - Entry accepted when req_valid_i && req_ready_o.
  - req_ready_o = !full, registered-count based.
  - Push and pop in the same cycle when neither full nor empty leave the count unchanged.
  - A push when full is never accepted; a pop when empty never occurs.
- FSM states S_IDLE, S_ISSUE, S_EXEC, S_SETTLE, S_RESP:
  - S_IDLE: if FIFO non-empty and stk_ready_i, pop the head into the command register and go to S_ISSUE; else stay.
  - S_ISSUE: exactly one strobe is high, decoded from the command op (stk_push_o / stk_pop_o / stk_index_read_o / stk_index_write_o). Go to S_EXEC.
  - S_EXEC: all strobes low. Register stk_data_i for POP/IDX_RD (the stack unit drives data combinationally this cycle). Go to S_SETTLE.
  - S_SETTLE: sample stk_overflow_i | stk_underflow_i into resp_err. Set ovf_sticky_o[sel] / unf_sticky_o[sel]. Load the response registers. Go to S_RESP.
  - S_RESP: resp_valid_o=1 with all resp_* stable. On resp_ready_i go to S_IDLE; else hold.
- stk_select_o, stk_offset_o and stk_data_o come from the command register. They are held stable from S_ISSUE through S_SETTLE, because the stack unit samples offset and data in its op cycle.
- Strobes depend only on registers (state + command), never on inputs.
- Latency:
  - Request accepted in cycle A with an empty FIFO and idle FSM → S_ISSUE in A+2, resp_valid_o in A+5.
  - Back-to-back commands with resp_ready_i held high: one command per 5 cycles.
- Sticky flags: sticky_clear_i clears both vectors. If clear and set coincide, set wins for that bit.
- stk_ready_i low in S_IDLE stalls issue; nothing else is affected.
- Underflowed POP/IDX_RD returns resp_data_o=0, resp_err_o=1.

Decomposition:
- Package stack_pkg holds:
  - stack_op_t enum (PUSH, POP, IDX_RD, IDX_WR).
  - stack_cmd_t struct (op, stack, offset, data, tag).
  - seq_state_t enum.
  - Constants NUM_STACKS=8, STACK_DATA_W=32, STACK_OFS_W=6.
- One sub-module: stack_cmd_fifo, a parameterised synchronous FIFO of stack_cmd_t with full/empty/count.

Test Plan:
- PUSH stack 2 data 0xDEADBEEF tag 3, then POP stack 2 tag 4 → responses in order: first (tag 3, err 0, data 0), second (tag 4, data 0xDEADBEEF, err 0).
- POP empty stack 5 → resp_err_o=1, resp_data_o=0, unf_sticky_o=8'h20. Then sticky_clear_i → 8'h00.
- Push 1,2,3 to stack 0, IDX_RD offset 2 → data 1. IDX_WR offset 0 data 9, then POP → 9. IDX_RD offset 5 → err 1.
- 63 PUSHes to stack 7 → last response err=1, ovf_sticky_o[7]=1.
- FIFO fill: hold resp_ready_i=0 and issue 6 requests → req_ready_o falls after FIFO_DEPTH+1 accepted. Release → all tags returned in order, nothing dropped.
- Assert rst_ni low during S_EXEC → resp_valid_o=0, req_ready_o=1, busy_o=0 immediately; the next request completes normally.

Source files
------------

// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
// Shared types and constants for the 8-stack command sequencer:
//   stack_op_t   - command opcode (PUSH / POP / IDX_RD / IDX_WR)
//   stack_cmd_t  - one buffered command (op, stack, offset, data, tag)
//   seq_state_t  - sequencer FSM state encoding
// The tag field is sized to CMD_TAG_W; the sequencer's TAG_W parameter
// must not exceed it.
// ---------------------------------------------------------------------------
package stack_pkg;

    localparam int NUM_STACKS   = 8;
    localparam int STACK_DATA_W = 32;
    localparam int STACK_OFS_W  = 6;
    localparam int STACK_SEL_W  = 3;
    localparam int CMD_TAG_W    = 16;

    typedef enum logic [1:0] {
        OP_PUSH   = 2'd0,
        OP_POP    = 2'd1,
        OP_IDX_RD = 2'd2,
        OP_IDX_WR = 2'd3
    } stack_op_t;

    typedef struct packed {
        stack_op_t                op;
        logic [STACK_SEL_W-1:0]   stack;
        logic [STACK_OFS_W-1:0]   offset;
        logic [STACK_DATA_W-1:0]  data;
        logic [CMD_TAG_W-1:0]     tag;
    } stack_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_EXEC   = 3'd2,
        S_SETTLE = 3'd3,
        S_RESP   = 3'd4
    } seq_state_t;

    // Commands that return data from the stack unit.
    function automatic logic isReadOp(input stack_op_t op);
        return (op == OP_POP) || (op == OP_IDX_RD);
    endfunction

endpackage

// File: rtl/stack_cmd_fifo.sv
// ---------------------------------------------------------------------------
// stack_cmd_fifo
// Synchronous FIFO of stack_cmd_t entries with registered occupancy count.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, wdata_i    write request and entry (ignored when full)
//   pop_i, rdata_o     read request and head entry (ignored when empty)
//   full_o, empty_o    occupancy flags derived from the registered count
//   count_o            number of stored entries
// ---------------------------------------------------------------------------
module stack_cmd_fifo
    import stack_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  stack_cmd_t                 wdata_i,
    input  logic                       pop_i,
    output stack_cmd_t                 rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stack_cmd_t           mem [DEPTH];
    logic [AW-1:0]        wrPtr_q;
    logic [AW-1:0]        rdPtr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 doPush;
    logic                 doPop;

    // Flags come straight from the registered count so the request-side
    // ready never depends on same-cycle inputs.
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Pointer and count bookkeeping; a simultaneous push and pop leaves
    // the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_ONE;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + CNT_ONE;
            end else if (doPop && !doPush) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    // Storage array; contents need no reset because the count gates reads.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/stack_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// stack_cmd_sequencer
// Front-end for the 8-stack unit. Buffers tagged commands in a FIFO, issues
// each one to the stack unit with a one-cycle strobe, captures read data and
// overflow/underflow status, and returns one tagged response per command.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_*                          valid/ready command input
//   resp_*                         valid/ready tagged response output
//   stk_*_o / stk_*_i              stack unit command and status interface
//   ovf_sticky_o, unf_sticky_o     per-stack sticky error flags
//   sticky_clear_i                 clears both sticky vectors
//   busy_o                         FIFO holds work or FSM not idle
// ---------------------------------------------------------------------------
module stack_cmd_sequencer
    import stack_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [1:0]                 req_op_i,
    input  logic [STACK_SEL_W-1:0]     req_stack_i,
    input  logic [STACK_OFS_W-1:0]     req_offset_i,
    input  logic [STACK_DATA_W-1:0]    req_data_i,
    input  logic [TAG_W-1:0]           req_tag_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [STACK_DATA_W-1:0]    resp_data_o,
    output logic [1:0]                 resp_op_o,
    output logic [TAG_W-1:0]           resp_tag_o,
    output logic                       resp_err_o,
    output logic [STACK_SEL_W-1:0]     stk_select_o,
    output logic                       stk_push_o,
    output logic                       stk_pop_o,
    output logic                       stk_index_read_o,
    output logic                       stk_index_write_o,
    output logic [STACK_OFS_W-1:0]     stk_offset_o,
    output logic [STACK_DATA_W-1:0]    stk_data_o,
    input  logic [STACK_DATA_W-1:0]    stk_data_i,
    input  logic                       stk_ready_i,
    input  logic                       stk_overflow_i,
    input  logic                       stk_underflow_i,
    output logic [NUM_STACKS-1:0]      ovf_sticky_o,
    output logic [NUM_STACKS-1:0]      unf_sticky_o,
    input  logic                       sticky_clear_i,
    output logic                       busy_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    stack_cmd_t                 fifoWdata;
    stack_cmd_t                 fifoRdata;
    logic                       fifoPush;
    logic                       fifoPop;
    logic                       fifoFull;
    logic                       fifoEmpty;
    logic [CNT_W-1:0]           fifoCount;

    seq_state_t                 state_q,    state_d;
    stack_cmd_t                 cmd_q,      cmd_d;
    logic [STACK_DATA_W-1:0]    execData_q, execData_d;
    logic [STACK_DATA_W-1:0]    respData_q, respData_d;
    stack_op_t                  respOp_q,   respOp_d;
    logic [TAG_W-1:0]           respTag_q,  respTag_d;
    logic                       respErr_q,  respErr_d;
    logic [NUM_STACKS-1:0]      ovf_q,      ovf_d;
    logic [NUM_STACKS-1:0]      unf_q,      unf_d;

    // Pack the request fields into a FIFO entry.
    always_comb begin
        fifoWdata        = '0;
        fifoWdata.op     = stack_op_t'(req_op_i);
        fifoWdata.stack  = req_stack_i;
        fifoWdata.offset = req_offset_i;
        fifoWdata.data   = req_data_i;
        fifoWdata.tag    = CMD_TAG_W'(req_tag_i);
    end

    assign req_ready_o = !fifoFull;
    assign fifoPush    = req_valid_i && req_ready_o;

    stack_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifoPush),
        .wdata_i (fifoWdata),
        .pop_i   (fifoPop),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // Sequencer next-state logic. The command register is only reloaded in
    // S_IDLE, so select/offset/data stay stable from S_ISSUE to S_SETTLE.
    // Sticky flags: a clear is applied first so a coincident set wins.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        execData_d = execData_q;
        respData_d = respData_q;
        respOp_d   = respOp_q;
        respTag_d  = respTag_q;
        respErr_d  = respErr_q;
        fifoPop    = 1'b0;
        ovf_d      = sticky_clear_i ? '0 : ovf_q;
        unf_d      = sticky_clear_i ? '0 : unf_q;

        case (state_q)
            S_IDLE: begin
                if (!fifoEmpty && stk_ready_i) begin
                    fifoPop = 1'b1;
                    cmd_d   = fifoRdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                execData_d = isReadOp(cmd_q.op) ? stk_data_i : '0;
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                respErr_d  = stk_overflow_i | stk_underflow_i;
                respData_d = (isReadOp(cmd_q.op) && !stk_underflow_i) ? execData_q : '0;
                respOp_d   = cmd_q.op;
                respTag_d  = TAG_W'(cmd_q.tag);
                if (stk_overflow_i) begin
                    ovf_d[cmd_q.stack] = 1'b1;
                end
                if (stk_underflow_i) begin
                    unf_d[cmd_q.stack] = 1'b1;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, command and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            execData_q <= '0;
            respData_q <= '0;
            respOp_q   <= OP_PUSH;
            respTag_q  <= '0;
            respErr_q  <= 1'b0;
            ovf_q      <= '0;
            unf_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            execData_q <= execData_d;
            respData_q <= respData_d;
            respOp_q   <= respOp_d;
            respTag_q  <= respTag_d;
            respErr_q  <= respErr_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Strobes are decoded from registers only, so they are glitch-free and
    // independent of stack unit inputs.
    assign stk_push_o        = (state_q == S_ISSUE) && (cmd_q.op == OP_PUSH);
    assign stk_pop_o         = (state_q == S_ISSUE) && (cmd_q.op == OP_POP);
    assign stk_index_read_o  = (state_q == S_ISSUE) && (cmd_q.op == OP_IDX_RD);
    assign stk_index_write_o = (state_q == S_ISSUE) && (cmd_q.op == OP_IDX_WR);
    assign stk_select_o      = cmd_q.stack;
    assign stk_offset_o      = cmd_q.offset;
    assign stk_data_o        = cmd_q.data;

    assign resp_valid_o = (state_q == S_RESP);
    assign resp_data_o  = respData_q;
    assign resp_op_o    = respOp_q;
    assign resp_tag_o   = respTag_q;
    assign resp_err_o   = respErr_q;
    assign ovf_sticky_o = ovf_q;
    assign unf_sticky_o = unf_q;
    assign busy_o       = (fifoCount != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stack_cmd_sequencer
// Directed bench for stack_cmd_sequencer with a behavioural stack unit.
// Stimulus pushes hand-computed expected responses into a queue; a monitor
// pops and compares every accepted response.
// ---------------------------------------------------------------------------
module tb_stack_cmd_sequencer;

    localparam int TAG_W     = 4;
    localparam int STK_DEPTH = 62;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [2:0]  req_stack = '0;
    logic [5:0]  req_offset = '0;
    logic [31:0] req_data = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic [1:0]  resp_op;
    logic [TAG_W-1:0] resp_tag;
    logic        resp_err;
    logic [2:0]  stk_select;
    logic        stk_push, stk_pop, stk_idx_rd, stk_idx_wr;
    logic [5:0]  stk_offset;
    logic [31:0] stk_dout;
    logic [31:0] stk_din = '0;
    logic        stk_ready = 1'b1;
    logic        stk_ovf = 1'b0;
    logic        stk_unf = 1'b0;
    logic [7:0]  ovf_sticky, unf_sticky;
    logic        sticky_clear = 1'b0;
    logic        busy;

    int testsRun = 0;
    int failCount = 0;

    typedef struct {
        logic [31:0]      data;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;
    exp_t expQ[$];

    always #5 clk = ~clk;

    stack_cmd_sequencer #(.FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_op_i          (req_op),
        .req_stack_i       (req_stack),
        .req_offset_i      (req_offset),
        .req_data_i        (req_data),
        .req_tag_i         (req_tag),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_data_o       (resp_data),
        .resp_op_o         (resp_op),
        .resp_tag_o        (resp_tag),
        .resp_err_o        (resp_err),
        .stk_select_o      (stk_select),
        .stk_push_o        (stk_push),
        .stk_pop_o         (stk_pop),
        .stk_index_read_o  (stk_idx_rd),
        .stk_index_write_o (stk_idx_wr),
        .stk_offset_o      (stk_offset),
        .stk_data_o        (stk_dout),
        .stk_data_i        (stk_din),
        .stk_ready_i       (stk_ready),
        .stk_overflow_i    (stk_ovf),
        .stk_underflow_i   (stk_unf),
        .ovf_sticky_o      (ovf_sticky),
        .unf_sticky_o      (unf_sticky),
        .sticky_clear_i    (sticky_clear),
        .busy_o            (busy)
    );

    // Behavioural stack unit: the op happens at the edge ending the strobe
    // cycle, read data is visible the following cycle, and the error pulse
    // arrives one cycle later still. Each stack holds STK_DEPTH entries, so
    // the 63rd push into an empty stack overflows. Failed reads drive junk
    // data so the sequencer's zeroing of underflowed reads is observable.
    logic [31:0] mem [8][64];
    int          cnt [8] = '{default: 0};
    logic        ovfP1 = 1'b0;
    logic        unfP1 = 1'b0;

    always @(posedge clk) begin
        automatic int s = int'(stk_select);
        automatic int o = int'(stk_offset);
        ovfP1   <= 1'b0;
        unfP1   <= 1'b0;
        stk_ovf <= ovfP1;
        stk_unf <= unfP1;
        if (stk_push) begin
            if (cnt[s] >= STK_DEPTH) ovfP1 <= 1'b1;
            else begin
                mem[s][cnt[s]] <= stk_dout;
                cnt[s] <= cnt[s] + 1;
            end
        end
        if (stk_pop) begin
            if (cnt[s] == 0) begin
                unfP1   <= 1'b1;
                stk_din <= 32'hBAD0BAD0;
            end else begin
                stk_din <= mem[s][cnt[s]-1];
                cnt[s]  <= cnt[s] - 1;
            end
        end
        if (stk_idx_rd) begin
            if (o >= cnt[s]) begin
                unfP1   <= 1'b1;
                stk_din <= 32'hBAD0BAD0;
            end else stk_din <= mem[s][cnt[s]-1-o];
        end
        if (stk_idx_wr) begin
            if (o >= cnt[s]) unfP1 <= 1'b1;
            else mem[s][cnt[s]-1-o] <= stk_dout;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Response monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_resp", {28'd0, resp_tag}, 32'hFFFFFFFF);
            end else begin
                automatic exp_t e = expQ.pop_front();
                checkOutput("resp_tag",  32'(resp_tag), 32'(e.tag));
                checkOutput("resp_op",   32'(resp_op),  32'(e.op));
                checkOutput("resp_err",  32'(resp_err), 32'(e.err));
                checkOutput("resp_data", resp_data,     e.data);
            end
        end
    end

    // Drive one request until accepted and queue its expected response.
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] stack,
                                 input logic [5:0] offset, input logic [31:0] data,
                                 input logic [TAG_W-1:0] tag,
                                 input logic [31:0] expData, input logic expErr);
        automatic logic accepted = 1'b0;
        automatic int   budget = 0;
        exp_t e;
        req_valid = 1'b1; req_op = op; req_stack = stack;
        req_offset = offset; req_data = data; req_tag = tag;
        while (!accepted && budget < 400) begin
            @(negedge clk);
            accepted = req_ready;
            if (accepted) begin
                e.data = expData; e.op = op; e.tag = tag; e.err = expErr;
                expQ.push_back(e);
            end
            @(posedge clk); #1;
            budget++;
        end
        req_valid = 1'b0;
        if (!accepted) checkOutput("req_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain();
        automatic int n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        automatic int cyc;

        // Reset state.
        #12;
        checkOutput("rst_req_ready",  32'(req_ready),  32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_busy",       32'(busy),       32'd0);
        checkOutput("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // PUSH then POP on stack 2, with latency and stall checks.
        applyStimulus(2'd0, 3'd2, 6'd0, 32'hDEADBEEF, 4'd3, 32'd0, 1'b0);
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("first_resp_latency", 32'(cyc), 32'd5);
        waitDrain();
        stk_ready = 1'b0;
        applyStimulus(2'd1, 3'd2, 6'd0, 32'd0, 4'd4, 32'hDEADBEEF, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("stall_no_resp", 32'(resp_valid), 32'd0);
        checkOutput("stall_busy",    32'(busy),       32'd1);
        stk_ready = 1'b1;
        waitDrain();

        // POP from empty stack 5, then sticky clear.
        applyStimulus(2'd1, 3'd5, 6'd0, 32'd0, 4'd5, 32'd0, 1'b1);
        waitDrain();
        checkOutput("unf_sticky_5", 32'(unf_sticky), 32'h20);
        sticky_clear = 1'b1;
        @(posedge clk); #1;
        sticky_clear = 1'b0;
        checkOutput("unf_sticky_clr", 32'(unf_sticky), 32'h00);

        // Stack 0: push 1,2,3; IDX_RD 2 -> 1; IDX_WR 0 <- 9; POP -> 9; IDX_RD 5 -> err.
        applyStimulus(2'd0, 3'd0, 6'd0, 32'd1, 4'd6, 32'd0, 1'b0);
        applyStimulus(2'd0, 3'd0, 6'd0, 32'd2, 4'd7, 32'd0, 1'b0);
        applyStimulus(2'd0, 3'd0, 6'd0, 32'd3, 4'd8, 32'd0, 1'b0);
        applyStimulus(2'd2, 3'd0, 6'd2, 32'd0, 4'd9, 32'd1, 1'b0);
        applyStimulus(2'd3, 3'd0, 6'd0, 32'd9, 4'd10, 32'd0, 1'b0);
        applyStimulus(2'd1, 3'd0, 6'd0, 32'd0, 4'd11, 32'd9, 1'b0);
        applyStimulus(2'd2, 3'd0, 6'd5, 32'd0, 4'd12, 32'd0, 1'b1);
        waitDrain();
        checkOutput("unf_sticky_0", 32'(unf_sticky), 32'h01);

        // 63 pushes into stack 7: only the last overflows.
        for (int i = 0; i < 63; i++) begin
            applyStimulus(2'd0, 3'd7, 6'd0, 32'(i), 4'(i), 32'd0, (i == 62));
        end
        waitDrain();
        checkOutput("ovf_sticky_7", 32'(ovf_sticky), 32'h80);

        // FIFO fill with responses blocked: 5 accepted, then ready drops.
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'd0, 3'd1, 6'd0, 32'(i + 100), 4'(i), 32'd0, 1'b0);
        end
        checkOutput("fifo_full_ready", 32'(req_ready), 32'd0);
        checkOutput("fifo_full_busy",  32'(busy),      32'd1);
        resp_ready = 1'b1;
        applyStimulus(2'd0, 3'd1, 6'd0, 32'd105, 4'd5, 32'd0, 1'b0);
        waitDrain();

        // Reset while the command is in S_EXEC abandons it.
        applyStimulus(2'd0, 3'd3, 6'd0, 32'h55, 4'd9, 32'd0, 1'b0);
        @(posedge clk); #1;
        checkOutput("issue_push_strobe", 32'(stk_push), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        expQ.delete();
        checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("midrst_req_ready",  32'(req_ready),  32'd1);
        checkOutput("midrst_busy",       32'(busy),       32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(2'd1, 3'd3, 6'd0, 32'd0, 4'd10, 32'h55, 1'b0);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
